// File: rtl/fifo_wr_arb_pkg.sv
// Shared constants for the FIFO write-port arbiter: FSM encoding, default
// parameter values and the statistics counter width.
package fifo_wr_arb_pkg;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    localparam int NUM_REQ_DEF   = 4;
    localparam int DATA_W_DEF    = 8;
    localparam int MAX_BURST_DEF = 4;
    localparam int STAT_W        = 16;

    typedef logic [STAT_W-1:0] stat_t;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side bundle of the write arbiter. The master modport is the
// arbiter's view; slave is the view of the requesters plus FIFO write port.
interface fifo_wr_arbiter_if
    import fifo_wr_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic                      full;
    logic                      wr_en;
    logic [DATA_W-1:0]         wr_data;
    logic [NUM_REQ-1:0]        grant;
    logic                      busy;

    modport master (
        input  req, req_data, full,
        output ack, wr_en, wr_data, grant, busy
    );

    modport slave (
        output req, req_data, full,
        input  ack, wr_en, wr_data, grant, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward
// from last_owner+1 with wrap-around.
module rr_pick
    import fifo_wr_arb_pkg::*;
#(
    parameter int  NUM_REQ = NUM_REQ_DEF,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);
    int cand;

    always_comb begin
        pick  = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        // last_owner itself is scanned last, so it only wins when alone
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_owner) + k) % NUM_REQ;
            if (!valid && req[cand]) begin
                valid      = 1'b1;
                idx        = IDX_W'(cand);
                pick[cand] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded scheduler for the single FIFO write port.
// Optional per-requester beat and stall statistics: FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                      wr_clk,
    input  logic                      wr_rst,
    fifo_wr_arbiter_if.master         bus
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0] beat_count,
    output logic [STAT_W-1:0]         stall_cycles
`endif
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    logic [0:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic [NUM_REQ-1:0] pick;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;
    logic               owner_req;
    logic [DATA_W-1:0]  owner_data;
    logic               in_grant;
    logic               beat;

    // owner_q doubles as last_owner: it keeps the previous owner through IDLE
    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req        (bus.req),
        .last_owner (owner_q),
        .pick       (pick),
        .idx        (pick_idx),
        .valid      (pick_vld)
    );

    always_comb begin
        owner_req  = 1'b0;
        owner_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                owner_req  = bus.req[i];
                owner_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Reset masks the write port combinationally so nothing leaks mid-burst
    assign in_grant    = (state_q == GRANT) && !wr_rst;
    assign beat        = in_grant && owner_req && !bus.full;
    assign bus.wr_en   = beat;
    assign bus.ack     = beat ? grant_q : '0;
    assign bus.wr_data = beat ? owner_data : '0;
    assign bus.grant   = grant_q;
    assign bus.busy    = (state_q == GRANT);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        if (state_q == IDLE) begin
            if (pick_vld) begin
                state_d    = GRANT;
                grant_d    = pick;
                owner_d    = pick_idx;
                beat_cnt_d = '0;
            end
        end else begin
            if (!owner_req) begin
                state_d = IDLE;
                grant_d = '0;
            end else if (beat) begin
                if (beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= IDX_W'(NUM_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    function automatic stat_t sat_inc(input stat_t v);
        return (v == '1) ? v : v + stat_t'(1);
    endfunction

    logic [NUM_REQ-1:0][STAT_W-1:0] beat_count_q, beat_count_d;
    stat_t                          stall_cycles_q, stall_cycles_d;

    always_comb begin
        beat_count_d   = beat_count_q;
        stall_cycles_d = stall_cycles_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.ack[i]) beat_count_d[i] = sat_inc(beat_count_q[i]);
        end
        if (in_grant && owner_req && bus.full) stall_cycles_d = sat_inc(stall_cycles_q);
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            beat_count_q   <= '0;
            stall_cycles_q <= '0;
        end else begin
            beat_count_q   <= beat_count_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign beat_count   = beat_count_q;
    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: requesters are modelled as word queues
// tagged {id, seq}; expected grants, write patterns and words are hand-derived.
module tb_fifo_wr_arbiter;
    import fifo_wr_arb_pkg::*;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic wr_clk = 1'b0;
    logic wr_rst = 1'b1;
    always #5 wr_clk = ~wr_clk;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

`ifdef FIFO_WR_ARB_STATS_EN
    logic [NR*STAT_W-1:0] beat_count;
    logic [STAT_W-1:0]    stall_cycles;
`endif

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .wr_clk       (wr_clk),
        .wr_rst       (wr_rst),
        .bus          (bus)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .beat_count   (beat_count),
        .stall_cycles (stall_cycles)
`endif
    );

    int             n_cmp = 0;
    int             n_err = 0;
    int             remaining [NR];
    int             seq       [NR];
    logic [DW-1:0]  wq [$];
    logic [NR-1:0]  gnt_log [64];
    logic [63:0]    wen_log;
    logic [63:0]    full_sched;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < NR; i++) begin
            bus.req[i]                = (remaining[i] > 0);
            bus.req_data[i*DW +: DW]  = {4'(i), 4'(seq[i])};
        end
    endtask

    task automatic cyc();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic do_reset();
        wr_rst     = 1'b1;
        full_sched = '0;
        bus.full   = 1'b0;
        for (int i = 0; i < NR; i++) begin
            remaining[i] = 0;
            seq[i]       = 0;
        end
        apply();
        cyc();
        cyc();
        wr_rst = 1'b0;
        wq.delete();
    endtask

    task automatic run(input int n);
        logic [NR-1:0] a;
        wen_log = '0;
        for (int c = 0; c < n; c++) begin
            bus.full = full_sched[c];
            @(negedge wr_clk);
            gnt_log[c] = bus.grant;
            wen_log[c] = bus.wr_en;
            a          = bus.ack;
            if (bus.wr_en) wq.push_back(bus.wr_data);
            check("full_inv", 32'(bus.wr_en & bus.full), 32'd0);
            check("ack_owner", 32'(bus.ack & ~bus.grant), 32'd0);
            cyc();
            for (int i = 0; i < NR; i++) begin
                if (a[i]) begin
                    remaining[i]--;
                    seq[i]++;
                end
            end
            apply();
        end
        bus.full = 1'b0;
    endtask

    task automatic check_words(input string tag, input logic [DW-1:0] exp [$]);
        logic [DW-1:0] got;
        check({tag, "_count"}, 32'(wq.size()), 32'(exp.size()));
        for (int k = 0; k < exp.size(); k++) begin
            got = (k < wq.size()) ? wq[k] : 'x;
            check($sformatf("%s_word%0d", tag, k), 32'(got), 32'(exp[k]));
        end
    endtask

    initial begin
        logic [DW-1:0] exp_w [$];

        // Reset held with every requester asking
        wr_rst     = 1'b1;
        full_sched = '0;
        bus.full   = 1'b0;
        for (int i = 0; i < NR; i++) begin
            remaining[i] = 1;
            seq[i]       = 0;
        end
        apply();
        cyc();
        cyc();
        @(negedge wr_clk);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_ack",   32'(bus.ack),   32'd0);
        check("rst_busy",  32'(bus.busy),  32'd0);
        cyc();
        wr_rst = 1'b0;
        run(2);
        check("first_idle",  32'(gnt_log[0]), 32'd0);
        check("first_grant", 32'(gnt_log[1]), 32'b0001);

        // Single requester, 6 words: 4-beat burst, idle gap, 2-beat burst
        do_reset();
        remaining[2] = 6;
        apply();
        run(10);
        check("single_grant", 32'(gnt_log[1]), 32'b0100);
        check("single_gap",   32'(gnt_log[5]), 32'd0);
        check("single_wen",   32'(wen_log[9:0]), 32'h0DE);
        exp_w = {8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
        check_words("single", exp_w);

        // All requesting: grant rotates 0,1,2,3 with 4 beats each
        do_reset();
        for (int i = 0; i < NR; i++) remaining[i] = 4;
        apply();
        run(21);
        check("rr_g0", 32'(gnt_log[1]),  32'b0001);
        check("rr_gap", 32'(gnt_log[5]), 32'd0);
        check("rr_g1", 32'(gnt_log[6]),  32'b0010);
        check("rr_g2", 32'(gnt_log[11]), 32'b0100);
        check("rr_g3", 32'(gnt_log[16]), 32'b1000);
        exp_w.delete();
        for (int k = 0; k < 16; k++) exp_w.push_back({4'(k / 4), 4'(k % 4)});
        check_words("rr", exp_w);
`ifdef FIFO_WR_ARB_STATS_EN
        for (int i = 0; i < NR; i++)
            check($sformatf("stat_beats%0d", i), 32'(beat_count[i*STAT_W +: STAT_W]), 32'd4);
`endif

        // full for 3 cycles after beat 2: burst stalls then completes
        do_reset();
        remaining[0] = 4;
        apply();
        full_sched = 64'h38;
        run(10);
        check("stall_hold", 32'(gnt_log[4]), 32'b0001);
        check("stall_wen",  32'(wen_log[9:0]), 32'h0C6);
        exp_w = {8'h00, 8'h01, 8'h02, 8'h03};
        check_words("stall", exp_w);
`ifdef FIFO_WR_ARB_STATS_EN
        check("stat_stall", 32'(stall_cycles), 32'd3);
`endif

        // Owner 1 drops after one beat; requester 3 takes over
        do_reset();
        remaining[1] = 1;
        remaining[3] = 2;
        apply();
        run(8);
        check("drop_g1",   32'(gnt_log[1]), 32'b0010);
        check("drop_idle", 32'(gnt_log[3]), 32'd0);
        check("drop_g3",   32'(gnt_log[4]), 32'b1000);
        check("drop_wen",  32'(wen_log[7:0]), 32'h32);
        exp_w = {8'h10, 8'h30, 8'h31};
        check_words("drop", exp_w);

        // Reset mid-burst: port closes at once, burst restarts with new grant
        do_reset();
        remaining[2] = 4;
        apply();
        run(3);
        wr_rst = 1'b1;
        @(negedge wr_clk);
        check("mrst_wr_en", 32'(bus.wr_en), 32'd0);
        check("mrst_ack",   32'(bus.ack),   32'd0);
        cyc();
        @(negedge wr_clk);
        check("mrst_grant", 32'(bus.grant), 32'd0);
        check("mrst_busy",  32'(bus.busy),  32'd0);
        cyc();
        wr_rst = 1'b0;
        run(4);
        check("mrst_regrant", 32'(gnt_log[1]), 32'b0100);
        exp_w = {8'h20, 8'h21, 8'h22, 8'h23};
        check_words("mrst", exp_w);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
